// File: rtl/dup_pkg.sv
// Shared types for the duplicate-FIFO consumer side.
package dup_pkg;

    // Drain sequence: first read, second read, then hold the forwarded word.
    typedef enum logic [1:0] {
        RD1,
        RD2,
        HOLD
    } dup_drain_state_t;

    // Number of times the duplicate FIFO presents each entry.
    localparam int DUP_READS = 2;

endpackage

// File: rtl/dup_pair_drain.sv
// Pops each duplicate-FIFO entry twice, compares the two reads, forwards the
// first read on a valid/ready channel and keeps entry and mismatch counters.
module dup_pair_drain
    import dup_pkg::*;
#(
    parameter int DW   = 16,
    parameter int CNTW = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [DW-1:0]   fifo_rdata,
    input  logic            fifo_empty,
    output logic            fifo_pop,
    output logic [DW-1:0]   out_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            mismatch,
    output logic [CNTW-1:0] pair_cnt,
    output logic [CNTW-1:0] err_cnt
);

    dup_drain_state_t state;
    dup_drain_state_t state_next;
    logic [DW-1:0]    first_q;
    logic             pop_first;
    logic             pop_second;

    // State register: a reset mid-pair abandons the pair and restarts at RD1.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values, independent of block order.
        if (rst) begin
            state <= RD1;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: each read waits for a non-empty FIFO, HOLD waits for
    // the downstream handshake (out_valid is always 1 in HOLD).
    always_comb begin
        // NOTE: default first, so every path assigns and no latch is inferred.
        state_next = state;
        unique case (state)
            RD1:     if (!fifo_empty) state_next = RD2;
            RD2:     if (!fifo_empty) state_next = HOLD;
            HOLD:    if (out_ready)   state_next = RD1;
            default: state_next = RD1;
        endcase
    end

    // Pop strobes: only in the two read states, never during reset or HOLD.
    always_comb begin
        pop_first  = 1'b0;
        pop_second = 1'b0;
        if (!rst && !fifo_empty) begin
            pop_first  = (state == RD1);
            pop_second = (state == RD2);
        end
        fifo_pop = pop_first | pop_second;
    end

    // Datapath: capture the first read, compare against the second, present
    // the first read downstream and update the counters on the second pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: first_q is a single register, not a memory, so it is reset
            // like everything else; a known value keeps comparisons defined.
            first_q   <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            mismatch  <= 1'b0;
            pair_cnt  <= '0;
            err_cnt   <= '0;
        end else begin
            mismatch <= 1'b0;

            if (pop_first) begin
                first_q <= fifo_rdata;
            end

            if (pop_second) begin
                out_data  <= first_q;
                out_valid <= 1'b1;
                pair_cnt  <= pair_cnt + 1'b1;
                if (fifo_rdata != first_q) begin
                    mismatch <= 1'b1;
                    if (err_cnt != '1) begin
                        err_cnt <= err_cnt + 1'b1;
                    end
                end
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dup_pair_drain.sv
// Randomized bench for dup_pair_drain: a behavioural duplicate-FIFO stub feeds
// the DUT, and a pair-level model predicts pops, forwarded words, mismatch
// pulses and both counters every cycle.
module tb_dup_pair_drain;

    localparam int DW    = 16;
    localparam int CNTW  = 8;
    localparam int DEPTH = 4;
    localparam int CMAX  = (1 << CNTW) - 1;

    logic            clk = 1'b0;
    logic            rst;
    logic [DW-1:0]   fifo_rdata;
    logic            fifo_empty;
    logic            fifo_pop;
    logic [DW-1:0]   out_data;
    logic            out_valid;
    logic            out_ready;
    logic            mismatch;
    logic [CNTW-1:0] pair_cnt;
    logic [CNTW-1:0] err_cnt;

    always #5 clk = ~clk;

    dup_pair_drain #(.DW(DW), .CNTW(CNTW)) dut (
        .clk        (clk),
        .rst        (rst),
        .fifo_rdata (fifo_rdata),
        .fifo_empty (fifo_empty),
        .fifo_pop   (fifo_pop),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .mismatch   (mismatch),
        .pair_cnt   (pair_cnt),
        .err_cnt    (err_cnt)
    );

    // Stub FIFO: each entry carries the word shown on the first and second read.
    typedef struct packed {
        logic [DW-1:0] a;
        logic [DW-1:0] b;
    } entry_t;

    entry_t        fq[$];
    int            rd_idx = 0;
    bit            stall  = 1'b0;
    int            n_pops = 0;

    // Pair-level reference model.
    int            m_pairs = 0;
    int            m_err   = 0;
    bit            m_hold  = 1'b0;
    bit            m_mm    = 1'b0;
    logic [DW-1:0] m_data  = '0;

    // Observation logs for directed scenarios.
    logic [DW-1:0] out_log[$];
    int            mm_pulses = 0;

    // Stimulus policy.
    int            rdy_mode  = 2;   // 0: always ready, 1: random, 2: never
    int            feed_left = 0;
    int            mm_pct    = 0;
    int            stall_pct = 0;

    int            n_checks = 0;
    int            n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void drive_fifo();
        fifo_empty = (fq.size() == 0) || stall;
        if (fq.size() == 0) fifo_rdata = 16'hDEAD;
        else                fifo_rdata = (rd_idx == 0) ? fq[0].a : fq[0].b;
    endfunction

    function automatic void push(input logic [DW-1:0] a, input logic [DW-1:0] b);
        entry_t e;
        e.a = a;
        e.b = b;
        fq.push_back(e);
        drive_fifo();
    endfunction

    // One clock: check at the falling edge, then advance stub and model after
    // the rising edge and apply the next stimulus.
    task automatic cycle();
        bit            pop_s;
        bit            hs_s;
        bit            rst_s;
        logic [DW-1:0] a;
        logic [DW-1:0] b;

        @(negedge clk);
        check("fifo_pop", fifo_pop, !rst && !fifo_empty && !m_hold);
        check("out_valid", out_valid, m_hold);
        if (m_hold) check("out_data", out_data, m_data);
        check("mismatch", mismatch, m_mm);
        check("pair_cnt", pair_cnt, m_pairs % (CMAX + 1));
        check("err_cnt", err_cnt, (m_err > CMAX) ? CMAX : m_err);
        if (mismatch) mm_pulses++;
        if (out_valid && out_ready) out_log.push_back(out_data);
        pop_s = fifo_pop;
        hs_s  = m_hold && out_ready;
        rst_s = rst;

        @(posedge clk);
        #1;
        m_mm = 1'b0;
        if (rst_s) begin
            m_pairs = 0;
            m_err   = 0;
            m_hold  = 1'b0;
            if (rd_idx == 1 && fq.size() > 0) void'(fq.pop_front());
            rd_idx = 0;
        end else begin
            if (hs_s) m_hold = 1'b0;
            if (pop_s && fq.size() > 0) begin
                n_pops++;
                if (rd_idx == 0) begin
                    rd_idx = 1;
                end else begin
                    m_pairs++;
                    m_data = fq[0].a;
                    m_hold = 1'b1;
                    if (fq[0].a != fq[0].b) begin
                        m_err++;
                        m_mm = 1'b1;
                    end
                    void'(fq.pop_front());
                    rd_idx = 0;
                end
            end
        end

        case (rdy_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b0;
        endcase
        if (feed_left > 0 && fq.size() < DEPTH && $urandom_range(0, 1) == 1) begin
            a = DW'($urandom());
            b = ($urandom_range(0, 99) < mm_pct) ? (a ^ (DW'(1) << $urandom_range(0, DW-1))) : a;
            push(a, b);
            feed_left--;
        end
        if (stall_pct > 0) stall = ($urandom_range(0, 99) < stall_pct);
        drive_fifo();
    endtask

    task automatic wait_first_read(input int budget, input string tag);
        int n = 0;
        while (rd_idx != 1 && n < budget) begin
            cycle();
            n++;
        end
        check({tag, "_timeout"}, rd_idx, 1);
    endtask

    task automatic wait_hold(input int budget, input string tag);
        int n = 0;
        while (!m_hold && n < budget) begin
            cycle();
            n++;
        end
        check({tag, "_timeout"}, m_hold, 1'b1);
    endtask

    task automatic drain(input int budget, input string tag);
        int n = 0;
        while ((feed_left > 0 || fq.size() > 0 || m_hold) && n < budget) begin
            cycle();
            n++;
        end
        check({tag, "_timeout"}, fq.size() + (m_hold ? 1 : 0) + feed_left, 0);
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;

        rst       = 1'b1;
        out_ready = 1'b0;
        drive_fifo();

        // Reset for two cycles with entries already waiting: no pop allowed.
        push(16'h1234, 16'h1234);
        push(16'hBEEF, 16'hBEEF);
        repeat (2) cycle();
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_pair_cnt", pair_cnt, 0);
        check("rst_err_cnt", err_cnt, 0);
        rst = 1'b0;

        // Two clean entries with downstream always ready.
        rdy_mode = 0;
        n_pops   = 0;
        out_log.delete();
        drain(60, "t2");
        check("t2_pops", n_pops, 4);
        check("t2_pair_cnt", pair_cnt, 2);
        check("t2_err_cnt", err_cnt, 0);
        check("t2_count", out_log.size(), 2);
        if (out_log.size() == 2) begin
            check("t2_word0", out_log[0], 16'h1234);
            check("t2_word1", out_log[1], 16'hBEEF);
        end

        // Second read differs from the first.
        out_log.delete();
        mm_pulses = 0;
        push(16'h00AA, 16'h00AB);
        drain(40, "t3");
        check("t3_pulses", mm_pulses, 1);
        check("t3_err_cnt", err_cnt, 1);
        check("t3_count", out_log.size(), 1);
        if (out_log.size() == 1) check("t3_word", out_log[0], 16'h00AA);

        // FIFO runs empty between the two reads of an entry.
        out_log.delete();
        push(16'h5555, 16'h5555);
        wait_first_read(20, "t4_rd1");
        stall = 1'b1;
        drive_fifo();
        p0 = n_pops;
        repeat (5) cycle();
        check("t4_stall_pops", n_pops - p0, 0);
        stall = 1'b0;
        drive_fifo();
        drain(40, "t4");
        check("t4_count", out_log.size(), 1);
        if (out_log.size() == 1) check("t4_word", out_log[0], 16'h5555);

        // Downstream back-pressure in HOLD with three entries still queued.
        out_log.delete();
        rdy_mode = 2;
        push(16'h0101, 16'h0101);
        push(16'h0202, 16'h0202);
        push(16'h0303, 16'h0303);
        push(16'h0404, 16'h0404);
        wait_hold(20, "t5_hold");
        p0 = n_pops;
        repeat (10) cycle();
        check("t5_hold_pops", n_pops - p0, 0);
        check("t5_held_word", out_data, 16'h0101);
        check("t5_queued", fq.size(), 3);
        rdy_mode = 0;
        drain(80, "t5");
        check("t5_count", out_log.size(), 4);
        if (out_log.size() == 4) check("t5_last", out_log[3], 16'h0404);

        // Reset while waiting for the second read abandons the pair.
        out_log.delete();
        push(16'h7777, 16'h7777);
        wait_first_read(20, "t6_rd1");
        stall = 1'b1;
        drive_fifo();
        rst = 1'b1;
        cycle();
        rst   = 1'b0;
        stall = 1'b0;
        drive_fifo();
        cycle();
        check("t6_pair_cnt", pair_cnt, 0);
        check("t6_out_valid", out_valid, 1'b0);
        push(16'h4242, 16'h4242);
        mm_pulses = 0;
        drain(40, "t6");
        check("t6_pulses", mm_pulses, 0);
        check("t6_count", out_log.size(), 1);
        if (out_log.size() == 1) check("t6_word", out_log[0], 16'h4242);
        check("t6_pair_after", pair_cnt, 1);

        // Random traffic: random data, errors, stalls and back-pressure.
        rdy_mode  = 1;
        stall_pct = 20;
        mm_pct    = 25;
        feed_left = 400;
        drain(20000, "rand");

        // Every entry corrupted: err_cnt must saturate, pair_cnt must wrap.
        stall_pct = 0;
        stall     = 1'b0;
        mm_pct    = 100;
        rdy_mode  = 0;
        feed_left = 300;
        drain(20000, "sat");
        check("sat_err_cnt", err_cnt, CMAX);
        check("wrap_pair_cnt", pair_cnt, 701 % (CMAX + 1));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
